// File: rtl/test_responder_if.sv
`timescale 1ns/1ps
// Host-link test responder bus: command-decoder inputs plus output-buffer frame interface.
// slave = responder side, master = decoder/buffer side.
interface test_responder_if #(
  parameter int OUT_BYTES = 32,
  parameter int CNT_W     = (OUT_BYTES > 1) ? $clog2(OUT_BYTES) : 1
);
  logic                   enable;
  logic                   mode;
  logic [7:0]             rx_d;
  logic                   rx_valid;
  logic [8*OUT_BYTES-1:0] out;
  logic [CNT_W-1:0]       out_bytecount;
  logic                   out_rdy;
  logic                   out_buf_busy;
  logic                   done;

  modport slave (
    input  enable, mode, rx_d, rx_valid, out_buf_busy,
    output out, out_bytecount, out_rdy, done
  );

  modport master (
    output enable, mode, rx_d, rx_valid, out_buf_busy,
    input  out, out_bytecount, out_rdy, done
  );
endinterface

// File: rtl/test_responder.sv
`timescale 1ns/1ps
// Test-command responder: pattern or echo response, split into frames of up to OUT_BYTES.
// Define TEST_RESP_CHECKSUM_EN to append an XOR checksum byte to every response.
//
// state   | meaning
// IDLE    | waiting for enable, latches mode
// LEN     | echo: waiting for the length byte
// COLLECT | echo: capturing payload bytes
// SEND    | emits one frame once the buffer is not busy
// GAP     | one quiet cycle between frames
// DONE    | response complete, held until enable falls
module test_responder #(
  parameter int         OUT_BYTES    = 32,
  parameter int         ECHO_DEPTH   = 16,
  parameter logic [7:0] PATTERN_BYTE = 8'hFE,
  parameter int         PATTERN_LEN  = 2,
  parameter int         CNT_W        = (OUT_BYTES > 1) ? $clog2(OUT_BYTES) : 1
) (
  input logic            clk,
  input logic            rst_n,
  test_responder_if.slave bus
);

`ifdef TEST_RESP_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif
  // Wide enough for ECHO_DEPTH (max 255) plus the checksum byte.
  localparam int IDX_W = 9;

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_COLLECT, S_SEND, S_GAP, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic                   mode_q, mode_d;
  logic [7:0]             rx_total_q, rx_total_d;
  logic [7:0]             cap_cnt_q, cap_cnt_d;
  logic [IDX_W-1:0]       pay_len_q, pay_len_d;
  logic [IDX_W-1:0]       rd_idx_q, rd_idx_d;
  logic [IDX_W-1:0]       remain_q, remain_d;
  logic [7:0]             csum_q, csum_d;
  logic [7:0]             buf_q [ECHO_DEPTH];
  logic [7:0]             buf_d [ECHO_DEPTH];
  logic [8*OUT_BYTES-1:0] out_q, out_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   rdy_q, rdy_d;
  logic                   done_q, done_d;

  logic [IDX_W-1:0]       frame_n;
  logic [8*OUT_BYTES-1:0] frame_bytes;
  logic [7:0]             src_byte;
  int                     src_idx;
  logic                   last_rx;

  // Length byte counts the unclamped total, so excess bytes are swallowed here.
  assign last_rx = ({1'b0, cap_cnt_q} + 9'd1) == {1'b0, rx_total_q};

  // All state advances on the falling edge of clk.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      mode_q     <= 1'b0;
      rx_total_q <= 8'h00;
      cap_cnt_q  <= 8'h00;
      pay_len_q  <= '0;
      rd_idx_q   <= '0;
      remain_q   <= '0;
      csum_q     <= 8'h00;
      out_q      <= '0;
      cnt_q      <= '0;
      rdy_q      <= 1'b0;
      done_q     <= 1'b0;
      for (int i = 0; i < ECHO_DEPTH; i++) buf_q[i] <= 8'h00;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      rx_total_q <= rx_total_d;
      cap_cnt_q  <= cap_cnt_d;
      pay_len_q  <= pay_len_d;
      rd_idx_q   <= rd_idx_d;
      remain_q   <= remain_d;
      csum_q     <= csum_d;
      out_q      <= out_d;
      cnt_q      <= cnt_d;
      rdy_q      <= rdy_d;
      done_q     <= done_d;
      buf_q      <= buf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!bus.enable) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:    state_d = bus.mode ? S_LEN : S_SEND;
        S_LEN:     if (bus.rx_valid)
                     state_d = (bus.rx_d != 8'h00) ? S_COLLECT : (CSUM_EN ? S_SEND : S_DONE);
        S_COLLECT: if (bus.rx_valid && last_rx) state_d = S_SEND;
        S_SEND:    if (!bus.out_buf_busy) state_d = (remain_q == frame_n) ? S_DONE : S_GAP;
        S_GAP:     state_d = S_SEND;
        S_DONE:    state_d = S_DONE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // Frame assembly: byte i of the frame comes from read index rd_idx_q + i.
  always_comb begin
    frame_n     = (remain_q > IDX_W'(OUT_BYTES)) ? IDX_W'(OUT_BYTES) : remain_q;
    frame_bytes = '0;
    src_idx     = 0;
    src_byte    = 8'h00;
    for (int i = 0; i < OUT_BYTES; i++) begin
      src_idx  = int'(rd_idx_q) + i;
      src_byte = mode_q ? 8'h00 : PATTERN_BYTE;
      if (mode_q) begin
        for (int j = 0; j < ECHO_DEPTH; j++)
          if (j == src_idx) src_byte = buf_q[j];
      end
      if (CSUM_EN && (src_idx == int'(pay_len_q))) src_byte = csum_q;
      if (i < int'(frame_n)) frame_bytes[8*i +: 8] = src_byte;
    end
  end

  always_comb begin
    mode_d     = mode_q;
    rx_total_d = rx_total_q;
    cap_cnt_d  = cap_cnt_q;
    pay_len_d  = pay_len_q;
    rd_idx_d   = rd_idx_q;
    remain_d   = remain_q;
    csum_d     = csum_q;
    buf_d      = buf_q;
    out_d      = out_q;
    cnt_d      = cnt_q;
    rdy_d      = 1'b0;
    done_d     = done_q;
    if (!bus.enable) begin
      cap_cnt_d = 8'h00;
      done_d    = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          mode_d    = bus.mode;
          rd_idx_d  = '0;
          cap_cnt_d = 8'h00;
          csum_d    = 8'h00;
          if (!bus.mode) begin
            pay_len_d = IDX_W'(PATTERN_LEN);
            remain_d  = IDX_W'(PATTERN_LEN) + IDX_W'(CSUM_EN);
            csum_d    = (PATTERN_LEN % 2 == 1) ? PATTERN_BYTE : 8'h00;
          end
        end
        S_LEN: begin
          if (bus.rx_valid) begin
            rx_total_d = bus.rx_d;
            pay_len_d  = (bus.rx_d > 8'(ECHO_DEPTH)) ? IDX_W'(ECHO_DEPTH) : {1'b0, bus.rx_d};
            remain_d   = pay_len_d + IDX_W'(CSUM_EN);
            if ((bus.rx_d == 8'h00) && !CSUM_EN) done_d = 1'b1;
          end
        end
        S_COLLECT: begin
          if (bus.rx_valid) begin
            if (cap_cnt_q < 8'(ECHO_DEPTH)) begin
              for (int i = 0; i < ECHO_DEPTH; i++)
                if (8'(i) == cap_cnt_q) buf_d[i] = bus.rx_d;
              csum_d = csum_q ^ bus.rx_d;
            end
            cap_cnt_d = cap_cnt_q + 8'd1;
          end
        end
        S_SEND: begin
          if (!bus.out_buf_busy) begin
            rdy_d    = 1'b1;
            out_d    = frame_bytes;
            cnt_d    = CNT_W'(frame_n - 9'd1);
            rd_idx_d = rd_idx_q + frame_n;
            remain_d = remain_q - frame_n;
            if (remain_q == frame_n) done_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.out           = out_q;
  assign bus.out_bytecount = cnt_q;
  assign bus.out_rdy       = rdy_q;
  assign bus.done          = done_q;

endmodule

// File: tb/tb_test_responder.sv
`timescale 1ns/1ps
// Randomised bench for test_responder: transaction-level byte-stream model split into frames,
// plus directed literal checks. Honors TEST_RESP_CHECKSUM_EN the same way as the design.
module tb_test_responder;
  localparam int         OB = 4;
  localparam int         ED = 16;
  localparam logic [7:0] PB = 8'hFE;
  localparam int         PL = 2;

  typedef struct {
    logic [8*OB-1:0] data;
    int              cnt;
  } frame_t;

  logic clk;
  logic rst_n;
  test_responder_if #(.OUT_BYTES(OB)) bus();

  test_responder #(
    .OUT_BYTES(OB), .ECHO_DEPTH(ED), .PATTERN_BYTE(PB), .PATTERN_LEN(PL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     n_checks = 0;
  int     n_fail   = 0;
  int     busy_pct = 0;
  frame_t exp_q[$];
  frame_t cmp_f;
  logic   last_busy = 1'b0;
  logic   prev_rdy  = 1'b0;
  logic   prev_done = 1'b0;
  int     rl, ra;
  logic [7:0] q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic rand_busy();
    return ($urandom_range(0, 99) < busy_pct);
  endfunction

  // Model: full response byte stream, chopped into OB-byte frames.
  task automatic expect_stream(input logic [7:0] pl[$]);
    logic [7:0] s[$];
    frame_t     f;
    s = pl;
`ifdef TEST_RESP_CHECKSUM_EN
    begin
      logic [7:0] x;
      x = 8'h00;
      foreach (pl[k]) x ^= pl[k];
      s.push_back(x);
    end
`endif
    while (s.size() > 0) begin
      f.data = '0;
      f.cnt  = 0;
      while (s.size() > 0 && f.cnt < OB) begin
        f.data[8*f.cnt +: 8] = s.pop_front();
        f.cnt++;
      end
      exp_q.push_back(f);
    end
  endtask

  always @(negedge clk) last_busy = bus.out_buf_busy;

  always @(posedge clk) begin
    if (rst_n) begin
      if (bus.out_rdy) begin
        check("rdy_gap", prev_rdy, 0);
        check("rdy_when_busy", last_busy, 0);
        if (exp_q.size() == 0) begin
          check("unexpected_frame", bus.out_rdy, 0);
        end else begin
          cmp_f = exp_q.pop_front();
          check("frame_cnt", bus.out_bytecount, cmp_f.cnt - 1);
          check("frame_data", bus.out, cmp_f.data);
        end
      end
      if (bus.done && !prev_done) check("done_early", exp_q.size(), 0);
      prev_rdy  = bus.out_rdy;
      prev_done = bus.done;
    end
  end

  task automatic idle_cycle();
    @(posedge clk);
    bus.enable       = 1'b0;
    bus.rx_valid     = 1'($urandom);
    bus.rx_d         = 8'($urandom);
    bus.mode         = 1'($urandom);
    bus.out_buf_busy = rand_busy();
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    repeat ($urandom_range(0, max_gap)) begin
      @(posedge clk);
      bus.rx_valid     = 1'b0;
      bus.rx_d         = 8'($urandom);
      bus.mode         = 1'($urandom);
      bus.out_buf_busy = rand_busy();
    end
    @(posedge clk);
    bus.rx_valid     = 1'b1;
    bus.rx_d         = b;
    bus.out_buf_busy = rand_busy();
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clk);
      if (bus.done) ok = 1'b1;
      else begin
        bus.rx_valid     = 1'($urandom);
        bus.rx_d         = 8'($urandom);
        bus.mode         = 1'($urandom);
        bus.out_buf_busy = rand_busy();
      end
    end
  endtask

  task automatic finish_txn();
    bit ok;
    wait_done(400, ok);
    check("done_seen", ok, 1);
    repeat (3) begin
      @(posedge clk);
      bus.rx_valid     = 1'($urandom);
      bus.rx_d         = 8'($urandom);
      bus.mode         = 1'($urandom);
      bus.out_buf_busy = rand_busy();
    end
    check("done_hold", bus.done, 1);
    check("frames_left", exp_q.size(), 0);
    exp_q.delete();
    @(posedge clk);
    bus.enable   = 1'b0;
    bus.rx_valid = 1'b0;
    @(posedge clk);
    check("done_clear", bus.done, 0);
    check("rdy_after_clear", bus.out_rdy, 0);
  endtask

  task automatic run_pattern();
    logic [7:0] s[$];
    @(posedge clk);
    bus.enable       = 1'b1;
    bus.mode         = 1'b0;
    bus.rx_valid     = 1'($urandom);
    bus.rx_d         = 8'($urandom);
    bus.out_buf_busy = rand_busy();
    for (int k = 0; k < PL; k++) s.push_back(PB);
    expect_stream(s);
    finish_txn();
  endtask

  task automatic run_echo(input int L, input int max_gap, input int abort_after);
    logic [7:0] kept[$];
    logic [7:0] b;
    @(posedge clk);
    bus.enable       = 1'b1;
    bus.mode         = 1'b1;
    bus.rx_valid     = 1'b0;
    bus.out_buf_busy = rand_busy();
    send_byte(8'(L), max_gap);
    for (int k = 0; k < L; k++) begin
      if (k == abort_after) begin
        @(posedge clk);
        bus.enable   = 1'b0;
        bus.rx_valid = 1'b0;
        @(posedge clk);
        check("abort_done", bus.done, 0);
        check("abort_rdy", bus.out_rdy, 0);
        return;
      end
      b = 8'($urandom);
      if (k < ED) kept.push_back(b);
      send_byte(b, max_gap);
    end
    @(posedge clk);
    bus.rx_valid     = 1'b0;
    bus.out_buf_busy = rand_busy();
    expect_stream(kept);
    finish_txn();
  endtask

  // Back-to-back echo with busy low; returns on the cycle the first frame is due.
  task automatic timed_echo(input logic [7:0] pl[$]);
    busy_pct = 0;
    @(posedge clk);
    bus.enable       = 1'b1;
    bus.mode         = 1'b1;
    bus.rx_valid     = 1'b0;
    bus.out_buf_busy = 1'b0;
    send_byte(8'(pl.size()), 0);
    foreach (pl[k]) send_byte(pl[k], 0);
    @(posedge clk);
    bus.rx_valid = 1'b0;
    expect_stream(pl);
    check("echo_lat_early", bus.out_rdy, 0);
    @(posedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n            = 1'b0;
    bus.enable       = 1'b0;
    bus.mode         = 1'b0;
    bus.rx_d         = 8'h00;
    bus.rx_valid     = 1'b0;
    bus.out_buf_busy = 1'b0;
    repeat (3) @(posedge clk);
    check("rst_out", bus.out, 0);
    check("rst_cnt", bus.out_bytecount, 0);
    check("rst_rdy", bus.out_rdy, 0);
    check("rst_done", bus.done, 0);
    @(posedge clk);
    rst_n = 1'b1;
    @(posedge clk);

    // Pattern, not busy: frame one edge after enable is seen.
    busy_pct = 0;
    @(posedge clk);
    bus.enable = 1'b1;
    bus.mode   = 1'b0;
    q = {PB, PB};
    expect_stream(q);
    @(posedge clk);
    check("pat_early", bus.out_rdy, 0);
    bus.mode     = 1'b1;
    bus.rx_valid = 1'b1;
    bus.rx_d     = 8'h5A;
    @(posedge clk);
    check("pat_rdy", bus.out_rdy, 1);
`ifdef TEST_RESP_CHECKSUM_EN
    check("pat_data", bus.out[23:0], 24'h00FEFE);
    check("pat_cnt", bus.out_bytecount, 2);
`else
    check("pat_data", bus.out[15:0], 16'hFEFE);
    check("pat_cnt", bus.out_bytecount, 1);
`endif
    check("pat_done", bus.done, 1);
    @(posedge clk);
    check("pat_rdy_pulse", bus.out_rdy, 0);
    check("pat_done_hold", bus.done, 1);
    bus.enable   = 1'b0;
    bus.rx_valid = 1'b0;
    @(posedge clk);
    check("pat_done_clr", bus.done, 0);

    // Pattern stalled by busy for 5 cycles.
    @(posedge clk);
    bus.enable       = 1'b1;
    bus.mode         = 1'b0;
    bus.out_buf_busy = 1'b1;
    q = {PB, PB};
    expect_stream(q);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      check("busy_stall", bus.out_rdy, 0);
      if (i == 4) bus.out_buf_busy = 1'b0;
    end
    @(posedge clk);
    check("busy_release", bus.out_rdy, 1);
    finish_txn();

    // Echo 6 bytes split into 4 + 2 with one gap cycle.
    q = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    timed_echo(q);
    check("e6_rdy1", bus.out_rdy, 1);
    check("e6_data1", bus.out, 32'h44332211);
    check("e6_cnt1", bus.out_bytecount, 3);
    check("e6_done1", bus.done, 0);
    @(posedge clk);
    check("e6_gap", bus.out_rdy, 0);
    @(posedge clk);
    check("e6_rdy2", bus.out_rdy, 1);
`ifdef TEST_RESP_CHECKSUM_EN
    check("e6_data2", bus.out[23:0], 24'h776655);
    check("e6_cnt2", bus.out_bytecount, 2);
`else
    check("e6_data2", bus.out[15:0], 16'h6655);
    check("e6_cnt2", bus.out_bytecount, 1);
`endif
    check("e6_done2", bus.done, 1);
    finish_txn();

    // Over-long echo: clamped to ED bytes, excess consumed.
    busy_pct = 20;
    run_echo(20, 2, -1);

    // Abort mid-collect, then a clean echo.
    run_echo(8, 1, 3);
    q = {8'hAA, 8'hBB};
    timed_echo(q);
    check("ab_rdy", bus.out_rdy, 1);
    check("ab_data", bus.out[15:0], 16'hBBAA);
`ifdef TEST_RESP_CHECKSUM_EN
    check("ab_cnt", bus.out_bytecount, 2);
`else
    check("ab_cnt", bus.out_bytecount, 1);
`endif
    finish_txn();

    q = {8'h0F, 8'hF0};
    timed_echo(q);
`ifdef TEST_RESP_CHECKSUM_EN
    check("cs_data", bus.out[23:0], 24'hFFF00F);
    check("cs_cnt", bus.out_bytecount, 2);
`else
    check("cs_data", bus.out[15:0], 16'hF00F);
    check("cs_cnt", bus.out_bytecount, 1);
`endif
    finish_txn();

    run_echo(0, 1, -1);

    // Abort while stalled in SEND: nothing may be emitted.
    @(posedge clk);
    bus.enable       = 1'b1;
    bus.mode         = 1'b0;
    bus.out_buf_busy = 1'b1;
    repeat (3) begin
      @(posedge clk);
      check("stall_abort_rdy", bus.out_rdy, 0);
    end
    bus.enable       = 1'b0;
    bus.out_buf_busy = 1'b0;
    @(posedge clk);
    check("stall_abort_done", bus.done, 0);
    busy_pct = 0;
    repeat (3) idle_cycle();
    run_pattern();

    for (int t = 0; t < 40; t++) begin
      busy_pct = $urandom_range(0, 60);
      if ($urandom_range(0, 2) == 0) begin
        run_pattern();
      end else begin
        rl = $urandom_range(0, 24);
        ra = (rl > 0 && $urandom_range(0, 7) == 0) ? int'($urandom_range(0, rl - 1)) : -1;
        run_echo(rl, $urandom_range(0, 2), ra);
      end
      repeat ($urandom_range(0, 2)) idle_cycle();
    end

    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/test_responder.md
# test_responder

Parametrised test-command responder for the CPU's host link: while `enable` is high it builds a response and pushes it into the output buffer as one or more frames, then raises `done`. It replaces the single fixed-frame test handler. It adds a configurable fixed-pattern mode, an echo mode that captures bytes from `rx_d`, multi-frame splitting, and abort on `enable` drop. It sits between the command decoder (which drives `enable`, `mode`, `rx_d`, `rx_valid`) and the shared output buffer (`out*`, `out_buf_busy`).

## Interface
- `OUT_BYTES`, 32: width of `out` in bytes; maximum bytes per frame.
- `ECHO_DEPTH`, 16: echo capture buffer size in bytes, range 1..255.
- `PATTERN_BYTE`, 8'hFE: fill byte for pattern mode.
- `PATTERN_LEN`, 2: pattern-mode payload length, range 1..OUT_BYTES.
- `CNT_W`, $clog2(OUT_BYTES) (minimum 1): width of `out_bytecount`.

Ports:
- `clk` input 1: single clock. All state updates on the falling edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `enable` input 1: high = transaction active. Low = abort/idle.
- `mode` input 1: 0 = pattern, 1 = echo. Sampled on the IDLE→start edge only.
- `rx_d` input 8: received byte.
- `rx_valid` input 1: `rx_d` valid this cycle.
- `out` output 8*OUT_BYTES: frame payload. Byte i is in `out[8i+7:8i]`. Unused bytes are 0.
- `out_bytecount` output CNT_W: valid bytes in the frame minus 1.
- `out_rdy` output 1: one-cycle frame strobe.
- `out_buf_busy` input 1: output buffer cannot accept a frame.
- `done` output 1: response complete. Held until `enable` falls.

## Operation
- States: IDLE, LEN, COLLECT, SEND, GAP, DONE.
- Reset values: all outputs 0; state IDLE; capture count 0.
- IDLE: when `enable` is 1, latch `mode`.
  - mode 0: load PATTERN_LEN bytes of PATTERN_BYTE and go to SEND.
  - mode 1: go to LEN.
- LEN: the first `rx_valid` byte is length L.
  - L=0: go to DONE; no frame is sent.
  - L>ECHO_DEPTH: clamp to ECHO_DEPTH.
  - Otherwise go to COLLECT.
- COLLECT: store each `rx_valid` byte at the next buffer index. After the L-th byte, go to SEND.
  - If the sender gave more bytes than ECHO_DEPTH, the excess is consumed and discarded; the block stays in COLLECT until the original unclamped L bytes have arrived.
- SEND: when `out_buf_busy`=0, drive one frame of min(remaining, OUT_BYTES) bytes from the current read index, with `out_bytecount` = bytes-1 and `out_rdy`=1.
  - Remaining decrements by the frame size.
  - If remaining becomes 0, go to DONE; otherwise go to GAP.
- GAP: one cycle with `out_rdy`=0, then back to SEND. This gives the buffer one cycle to raise `out_buf_busy`.
- DONE: `done`=1 and all further activity is ignored.
- `enable`=0 in any state: next edge forces IDLE, clears `out_rdy`, `done` and the capture count. `out` and `out_bytecount` hold their last values.
- Once `done` is set, a new transaction needs `enable` low for at least one edge and then high again.

## Timing
- Pattern mode: the first `out_rdy` comes on the edge after the edge where `enable` is seen high, provided `out_buf_busy`=0.
- Echo mode: the first `out_rdy` comes on the edge after the edge that captured the last payload byte, if not busy.
- `out_rdy` is high for exactly one cycle per frame and never on consecutive cycles.
- `out` and `out_bytecount` are valid in the same cycle as `out_rdy`.
- `out_buf_busy` stalls SEND indefinitely with no loss of data.
- `done` rises on the same edge as the last frame's `out_rdy`.
- `rx_valid` is ignored in IDLE, SEND, GAP and DONE.

## Configuration
- `TEST_RESP_CHECKSUM_EN` defined: one extra byte is appended to every response. It is the XOR of all payload bytes and is counted in the frame length and split like any other byte. In echo mode with L=0, a single byte 8'h00 is sent instead of going straight to DONE.
- Not defined: the payload is sent unmodified with no trailing byte.

## Test plan
- Pattern, defaults, `out_buf_busy`=0, `enable` 0→1 -> next edge `out_rdy`=1 for 1 cycle, `out[15:0]`=16'hFEFE, `out_bytecount`=1, `done`=1 until `enable`=0.
- Echo, OUT_BYTES=4: send 6, then 11 22 33 44 55 66 -> frame 1 is 44 33 22 11 (`out[31:0]`=32'h44332211) with `out_bytecount`=3; one GAP cycle; frame 2 `out[15:0]`=16'h6655 with `out_bytecount`=1; `done` rises with frame 2.
- Echo, ECHO_DEPTH=16: L=20 with 20 bytes -> only 16 bytes are sent; state returns to SEND only after the 20th byte.
- Pattern with `out_buf_busy` held 1 for 5 cycles -> no `out_rdy` during those 5 cycles; frame sent on the first edge with busy=0.
- `enable` dropped in COLLECT after 3 of 8 bytes -> IDLE, no `out_rdy`, `done`=0. Re-enable with L=2 AA BB -> `out[15:0]`=16'hBBAA.
- With `TEST_RESP_CHECKSUM_EN`, echo 2 bytes 0F F0 -> `out[23:0]`=24'hFFF00F, `out_bytecount`=2.
